fft_mag_stream: RTL
===================

# fft_mag_stream

Streaming, parametrised magnitude unit between the FFT and the mel filter bank. It accepts signed complex FFT bins over a valid/ready handshake. Per sample it returns either the integer magnitude floor(sqrt(re²+im²)) or the power re²+im². Every result is tagged with its bin index and an end-of-frame flag. Full-throughput pipeline with global backpressure stall; the fixed-latency result ordering matches input order.

## Interface
- FFT_DATA_WIDTH, 16, width W of signed real/imag inputs (two's complement)
- MEL_DATA_WIDTH, 32, width of the magnitude/power output
- FFT_POINTS, 256, bins per frame; power of two, ≥ 2
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input sample present
- in_ready  output  1  block accepts the sample this cycle
- real_part  input  W  signed real part
- imag_part  input  W  signed imaginary part
- mode_power  input  1  1 = output re²+im²; 0 = output floor(sqrt(re²+im²)); sampled with the input beat
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- magnitude  output  MEL_DATA_WIDTH  result, unsigned
- out_bin  output  log2(FFT_POINTS)  bin index of the result
- out_last  output  1  result is bin FFT_POINTS-1

## Operation
- Handshake: input beat transfers when in_valid && in_ready. Output beat transfers when out_valid && out_ready.
- Stall enable en = !(out_valid && !out_ready). in_ready = en. When en = 0, every pipeline register, including valid bits and sideband, holds its value.
- Each stage carries a valid bit, so bubbles propagate as empty stages.
- Stage 1: signed squares re², im² (2W-bit unsigned each). mode_power and the bin index are captured here.
- Stage 2: sum S = re² + im², width 2W. The maximum S = 2^(2W-1), from (-2^(W-1))² × 2, fits without overflow.
- Stages 3..W+2: W-stage restoring integer square root of S, one result bit per stage, MSB first. The result is floor(sqrt(S)), W bits.
- S travels alongside the root stages unchanged, so both modes have identical latency and order is preserved.
- Output mux:
  - mode_power = 1: magnitude = S, zero-extended. If MEL_DATA_WIDTH < 2W and S ≥ 2^MEL_DATA_WIDTH, the output saturates to all ones.
  - mode_power = 0: magnitude = root, zero-extended.
- Bin counter:
  - Increments on each accepted input beat and wraps from FFT_POINTS-1 to 0.
  - Its pre-increment value is attached to the beat as out_bin.
  - out_last = (out_bin == FFT_POINTS-1).
- Mode may change every beat; each result uses its own beat's mode.

## Timing
- Latency: LAT = W+2 cycles from the input transfer edge to out_valid, with no stall (18 for W = 16).
- Throughput: 1 sample/cycle while out_ready = 1.
- Stall: each stall cycle adds exactly one cycle to the latency of every in-flight sample. Data and sideband are held stable while out_valid && !out_ready.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready (documented; a downstream skid buffer is optional).
- Reset, effective on the clock edge with rst = 1:
  - all valid bits = 0, bin counter = 0;
  - out_valid = 0, magnitude = 0, out_bin = 0, out_last = 0;
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation: in-flight samples are discarded and never appear at the output. The first beat after reset is bin 0.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.
- Inputs (0,0) give magnitude 0 in both modes.

## Test plan
- Sqrt mode, single beats (3,4), (5,12), (-8,15): magnitude 5, 13, 17 respectively, each exactly 18 cycles after acceptance (W = 16).
- Power mode (3,4) then sqrt mode (3,4) back-to-back, with the mode toggling per beat: outputs 25 then 5 on consecutive cycles.
- Extremes (-32768,-32768): sqrt 46340, power 2147483648. Also check (32767,0) → 32767, and (0,0) → 0.
- Streaming and backpressure:
  - stimulus: 40 consecutive random beats; out_ready held low for cycles 25–30;
  - required: no loss, no duplication, outputs in order, in_ready = 0 exactly while the stall holds, each output matching a reference model.
- Frame tagging with FFT_POINTS = 4 over 10 beats: out_bin sequence 0,1,2,3,0,1,2,3,0,1, with out_last high on the 4th and 8th results only.
- rst asserted for 1 cycle while 5 samples are in flight:
  - out_valid = 0 and magnitude = 0 on the next cycle; none of the 5 samples emerge;
  - the next accepted beat reports out_bin = 0.

Source files
------------

// File: rtl/fft_mag_stream.sv
// Streaming complex-bin magnitude/power unit between the FFT and the mel filter bank.
// Squares, sums, then a W-stage restoring square root; a single global stall freezes the pipe.
module fft_mag_stream #(
  parameter int FFT_DATA_WIDTH = 16,
  parameter int MEL_DATA_WIDTH = 32,
  parameter int FFT_POINTS     = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [FFT_DATA_WIDTH-1:0]       real_part,
  input  logic [FFT_DATA_WIDTH-1:0]       imag_part,
  input  logic                            mode_power,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [MEL_DATA_WIDTH-1:0]       magnitude,
  output logic [$clog2(FFT_POINTS)-1:0]   out_bin,
  output logic                            out_last
);

  localparam int W  = FFT_DATA_WIDTH;
  localparam int SW = 2 * W;
  localparam int BW = $clog2(FFT_POINTS);
  localparam int RW = W + 4;
  localparam int OW = (MEL_DATA_WIDTH > SW) ? MEL_DATA_WIDTH : SW;

  // One restoring square-root step: bring down two bits of S, try appending a 1 to the root.
  function automatic logic [RW+W-1:0] sqrt_step(
    input logic [RW-1:0] rem,
    input logic [W-1:0]  root,
    input logic [1:0]    pair
  );
    logic [RW-1:0] cur;
    logic [RW-1:0] trial;
    cur   = {rem[RW-3:0], pair};
    trial = {2'b00, root, 2'b01};
    if (cur >= trial) begin
      return {cur - trial, root[W-2:0], 1'b1};
    end else begin
      return {cur, root[W-2:0], 1'b0};
    end
  endfunction

  logic          en;
  logic [BW-1:0] bin_cnt;
  logic [SW-1:0] re_ext;
  logic [SW-1:0] im_ext;

  logic          s1_valid;
  logic [SW-1:0] s1_re2;
  logic [SW-1:0] s1_im2;
  logic          s1_mode;
  logic [BW-1:0] s1_bin;

  logic          rt_valid [0:W];
  logic [SW-1:0] rt_s     [0:W];
  logic [RW-1:0] rt_rem   [0:W];
  logic [W-1:0]  rt_root  [0:W];
  logic          rt_mode  [0:W];
  logic [BW-1:0] rt_bin   [0:W];

  logic [RW-1:0] nx_rem   [1:W];
  logic [W-1:0]  nx_root  [1:W];

  logic [OW-1:0]             s_wide;
  logic [OW-1:0]             sat_lim;
  logic [MEL_DATA_WIDTH-1:0] mag_sel;

  // in_ready follows out_ready combinationally; a full output register blocks the whole pipe.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Sign-extend so the low 2W bits of an unsigned product equal the signed square.
  assign re_ext = {{W{real_part[W-1]}}, real_part};
  assign im_ext = {{W{imag_part[W-1]}}, imag_part};

  // Bin counter: tags each accepted beat, wraps at the frame size.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt <= '0;
    end else if (in_valid && en) begin
      bin_cnt <= bin_cnt + BW'(1);
    end
  end

  // Stage 1: squares, mode and bin capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_re2   <= '0;
      s1_im2   <= '0;
      s1_mode  <= 1'b0;
      s1_bin   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_re2   <= re_ext * re_ext;
      s1_im2   <= im_ext * im_ext;
      s1_mode  <= mode_power;
      s1_bin   <= bin_cnt;
    end
  end

  // Next root/remainder for every square-root stage.
  always_comb begin
    for (int k = 1; k <= W; k++) begin
      {nx_rem[k], nx_root[k]} = sqrt_step(rt_rem[k-1], rt_root[k-1], rt_s[k-1][2*(W-k) +: 2]);
    end
  end

  // Stage 2 (index 0: sum) and root stages 1..W; S rides along unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= W; k++) begin
        rt_valid[k] <= 1'b0;
        rt_s[k]     <= '0;
        rt_rem[k]   <= '0;
        rt_root[k]  <= '0;
        rt_mode[k]  <= 1'b0;
        rt_bin[k]   <= '0;
      end
    end else if (en) begin
      rt_valid[0] <= s1_valid;
      rt_s[0]     <= s1_re2 + s1_im2;
      rt_rem[0]   <= '0;
      rt_root[0]  <= '0;
      rt_mode[0]  <= s1_mode;
      rt_bin[0]   <= s1_bin;
      for (int k = 1; k <= W; k++) begin
        rt_valid[k] <= rt_valid[k-1];
        rt_s[k]     <= rt_s[k-1];
        rt_rem[k]   <= nx_rem[k];
        rt_root[k]  <= nx_root[k];
        rt_mode[k]  <= rt_mode[k-1];
        rt_bin[k]   <= rt_bin[k-1];
      end
    end
  end

  // Result select; power saturates only when the output is narrower than S.
  always_comb begin
    s_wide  = OW'(rt_s[W]);
    sat_lim = OW'({MEL_DATA_WIDTH{1'b1}});
    mag_sel = '0;
    if (rt_mode[W]) begin
      if (s_wide > sat_lim) begin
        mag_sel = '1;
      end else begin
        mag_sel = MEL_DATA_WIDTH'(s_wide);
      end
    end else begin
      mag_sel = MEL_DATA_WIDTH'(rt_root[W]);
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      magnitude <= '0;
      out_bin   <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= rt_valid[W];
      magnitude <= mag_sel;
      out_bin   <= rt_bin[W];
      out_last  <= (rt_bin[W] == BW'(FFT_POINTS - 1));
    end
  end

endmodule
